// File: rtl/result_writeback.sv
`default_nettype none
// ============================================================================
// Module   : result_writeback
// Purpose  : Collects per-job ALU results through a small FIFO and writes
//            them to consecutive result-memory addresses when granted.
// Revision : 1.0 - initial release
// ============================================================================
module result_writeback #(
    parameter int                ADDR_W     = 8,
    parameter int                NUM_RES    = 16,
    parameter logic [ADDR_W-1:0] BASE_ADDR  = '0,
    parameter int                FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [19:0]       sum,
    input  logic              web,
    input  logic              mem_gnt,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              busy,
    output logic              done,
    output logic              ovf,
    output logic [7:0]        acc_cnt
);

    localparam int         c_PTR_W   = $clog2(FIFO_DEPTH);
    localparam int         c_CNT_W   = c_PTR_W + 1;
    localparam logic [7:0] c_NUM_RES = 8'(NUM_RES);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_RUN   = 2'd1;
    localparam logic [1:0] c_DRAIN = 2'd2;
    localparam logic [1:0] c_DONE  = 2'd3;

    logic [1:0]         r_state;
    logic [1:0]         w_state_nxt;

    logic [19:0]        r_fifo [FIFO_DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_CNT_W-1:0] r_count;
    logic [ADDR_W-1:0]  r_widx;
    logic               r_ovf;
    logic [7:0]         r_acc_cnt;

    logic w_empty;
    logic w_full;
    logic w_accept;
    logic w_push;
    logic w_pop;
    logic w_drop;
    logic w_clear;
    logic w_last;

    assign w_empty  = (r_count == '0);
    assign w_full   = (r_count == c_CNT_W'(FIFO_DEPTH));
    assign w_accept = (r_state == c_RUN) && web;
    assign w_pop    = mem_we;
    // A full FIFO can still take a beat when the head leaves on the same edge.
    assign w_push   = w_accept && (!w_full || w_pop);
    assign w_drop   = w_accept && w_full && !w_pop;
    assign w_clear  = (r_state == c_IDLE) && start;
    assign w_last   = w_accept && (r_acc_cnt == c_NUM_RES - 8'd1);

    // ---------------------------------------------------------------- state
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE:  if (start)              w_state_nxt = c_RUN;
            c_RUN:   if (w_last)             w_state_nxt = c_DRAIN;
            c_DRAIN: if (w_empty && !w_pop)  w_state_nxt = c_DONE;
            c_DONE:                          w_state_nxt = c_IDLE;
            default:                         w_state_nxt = c_IDLE;
        endcase
    end

    always_comb begin
        busy   = 1'b0;
        done   = 1'b0;
        mem_we = 1'b0;
        case (r_state)
            c_RUN, c_DRAIN: begin
                busy   = 1'b1;
                mem_we = !w_empty && mem_gnt;
            end
            c_DONE:  done = 1'b1;
            default: ;
        endcase
    end

    // ------------------------------------------------------------- datapath
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
            r_widx    <= '0;
            r_ovf     <= 1'b0;
            r_acc_cnt <= '0;
        end else if (w_clear) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
            r_widx    <= '0;
            r_ovf     <= 1'b0;
            r_acc_cnt <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
                r_widx   <= r_widx + ADDR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CNT_W'(1);
                2'b01:   r_count <= r_count - c_CNT_W'(1);
                default: r_count <= r_count;
            endcase
            if (w_drop) begin
                r_ovf <= 1'b1;
            end
            if (w_accept && (r_acc_cnt < c_NUM_RES)) begin
                r_acc_cnt <= r_acc_cnt + 8'd1;
            end
        end
    end

    // Storage needs no reset: occupancy is reset, so stale entries are never read.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo[r_wr_ptr] <= sum;
        end
    end

    assign mem_wdata = {12'b0, r_fifo[r_rd_ptr]};
    assign mem_addr  = BASE_ADDR + r_widx;
    assign ovf       = r_ovf;
    assign acc_cnt   = r_acc_cnt;

endmodule
`default_nettype wire

// File: tb/tb_result_writeback.sv
`default_nettype none
// ============================================================================
// Module   : tb_result_writeback
// Purpose  : Directed self-checking bench for result_writeback.
// Revision : 1.0 - initial release
// ============================================================================
module tb_result_writeback;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [19:0] sum;
    logic        web;
    logic        gnt;

    logic        w_a_we, w_a_busy, w_a_done, w_a_ovf;
    logic [7:0]  w_a_addr, w_a_acc;
    logic [31:0] w_a_wdata;
    logic        w_b_we, w_b_busy, w_b_done, w_b_ovf;
    logic [7:0]  w_b_addr, w_b_acc;
    logic [31:0] w_b_wdata;
    logic        w_c_we, w_c_busy, w_c_done, w_c_ovf;
    logic [7:0]  w_c_addr, w_c_acc;
    logic [31:0] w_c_wdata;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    result_writeback #(.ADDR_W(8), .NUM_RES(4), .BASE_ADDR(8'h00), .FIFO_DEPTH(4)) dut_a (
        .clk(clk), .rst(rst), .start(start), .sum(sum), .web(web), .mem_gnt(gnt),
        .mem_we(w_a_we), .mem_addr(w_a_addr), .mem_wdata(w_a_wdata),
        .busy(w_a_busy), .done(w_a_done), .ovf(w_a_ovf), .acc_cnt(w_a_acc));

    result_writeback #(.ADDR_W(8), .NUM_RES(6), .BASE_ADDR(8'h00), .FIFO_DEPTH(4)) dut_b (
        .clk(clk), .rst(rst), .start(start), .sum(sum), .web(web), .mem_gnt(gnt),
        .mem_we(w_b_we), .mem_addr(w_b_addr), .mem_wdata(w_b_wdata),
        .busy(w_b_busy), .done(w_b_done), .ovf(w_b_ovf), .acc_cnt(w_b_acc));

    result_writeback #(.ADDR_W(8), .NUM_RES(4), .BASE_ADDR(8'hFE), .FIFO_DEPTH(4)) dut_c (
        .clk(clk), .rst(rst), .start(start), .sum(sum), .web(web), .mem_gnt(gnt),
        .mem_we(w_c_we), .mem_addr(w_c_addr), .mem_wdata(w_c_wdata),
        .busy(w_c_busy), .done(w_c_done), .ovf(w_c_ovf), .acc_cnt(w_c_acc));

    // Write/done log, sampled mid-cycle when the strobe is stable for the next edge.
    logic [7:0]  a_addr_q[$], b_addr_q[$], c_addr_q[$];
    logic [31:0] a_data_q[$], b_data_q[$], c_data_q[$];
    int a_dones = 0, b_dones = 0, c_dones = 0;

    always @(negedge clk) begin
        if (w_a_we) begin a_addr_q.push_back(w_a_addr); a_data_q.push_back(w_a_wdata); end
        if (w_b_we) begin b_addr_q.push_back(w_b_addr); b_data_q.push_back(w_b_wdata); end
        if (w_c_we) begin c_addr_q.push_back(w_c_addr); c_data_q.push_back(w_c_wdata); end
        if (w_a_done) a_dones++;
        if (w_b_done) b_dones++;
        if (w_c_done) c_dones++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0; start = 1'b0; web = 1'b0; sum = '0; gnt = 1'b0;
        cyc();
        cyc();
        rst = 1'b1;
    endtask

    int na, nb, nc, nd, nlog;
    logic [7:0]  exp_addr [4];
    logic [31:0] exp_data [4];

    initial begin
        // ------------------------------------------------ reset values
        do_reset();
        chk("rst_busy", w_a_busy, 1'b0);
        chk("rst_done", w_a_done, 1'b0);
        chk("rst_ovf",  w_a_ovf,  1'b0);
        chk("rst_acc",  w_a_acc,  8'd0);
        chk("rst_we",   w_a_we,   1'b0);

        // ------------------------------------------------ basic job
        na = a_addr_q.size(); nd = a_dones;
        gnt = 1'b1; start = 1'b1;
        cyc(); start = 1'b0; #1;
        chk("p1_busy", w_a_busy, 1'b1);
        for (int i = 1; i <= 4; i++) begin
            web = 1'b1; sum = 20'(i);
            cyc(); #1;
            chk("p1_acc",   w_a_acc,   32'(i));
            chk("p1_we",    w_a_we,    1'b1);
            chk("p1_wdata", w_a_wdata, 32'(i));
            chk("p1_addr",  w_a_addr,  32'(i - 1));
        end
        web = 1'b0;
        cyc(); #1;
        chk("p1_drain_busy", w_a_busy, 1'b1);
        chk("p1_drain_we",   w_a_we,   1'b0);
        cyc(); #1;
        chk("p1_done",      w_a_done, 1'b1);
        chk("p1_done_busy", w_a_busy, 1'b0);
        cyc(); #1;
        chk("p1_done_fall", w_a_done, 1'b0);
        chk("p1_ovf",       w_a_ovf,  1'b0);
        chk("p1_nwr",       a_addr_q.size() - na, 4);
        chk("p1_ndone",     a_dones - nd, 1);

        // ------------------------------------------------ stall then release
        do_reset();
        na = a_addr_q.size(); nd = a_dones;
        gnt = 1'b0; start = 1'b1;
        cyc(); start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            web = 1'b1; sum = 20'(5 + i);
            cyc(); #1;
            chk("p2_hold_we",    w_a_we,    1'b0);
            chk("p2_hold_addr",  w_a_addr,  8'd0);
            chk("p2_hold_wdata", w_a_wdata, 32'd5);
        end
        web = 1'b0; gnt = 1'b1; #1;
        chk("p2_rel_we",    w_a_we,    1'b1);
        chk("p2_rel_wdata", w_a_wdata, 32'd5);
        chk("p2_acc",       w_a_acc,   8'd4);
        for (int i = 1; i < 4; i++) begin
            cyc(); #1;
            chk("p2_we",    w_a_we,    1'b1);
            chk("p2_wdata", w_a_wdata, 32'(5 + i));
            chk("p2_addr",  w_a_addr,  32'(i));
            chk("p2_busy",  w_a_busy,  1'b1);
        end
        cyc(); #1;
        chk("p2_empty_we", w_a_we,   1'b0);
        chk("p2_busy_dr",  w_a_busy, 1'b1);
        cyc(); #1;
        chk("p2_done", w_a_done, 1'b1);
        chk("p2_ovf",  w_a_ovf,  1'b0);
        cyc(); #1;
        chk("p2_nwr", a_addr_q.size() - na, 4);
        for (int i = 0; i < 4; i++) begin
            chk("p2_log_addr", a_addr_q[na + i], 32'(i));
            chk("p2_log_data", a_data_q[na + i], 32'(5 + i));
        end

        // ------------------------------------------------ overflow (NUM_RES=6)
        do_reset();
        nb = b_addr_q.size(); nd = b_dones;
        exp_data[0] = 32'h000FFFFF; exp_data[1] = 32'd1;
        exp_data[2] = 32'd2;        exp_data[3] = 32'd3;
        gnt = 1'b0; start = 1'b1;
        cyc(); start = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            web = 1'b1; sum = (k == 1) ? 20'hFFFFF : 20'(k - 1);
            cyc(); #1;
            chk("p3_acc", w_b_acc, 32'(k));
            chk("p3_ovf", w_b_ovf, (k >= 5) ? 1'b1 : 1'b0);
        end
        web = 1'b0;
        chk("p3_busy", w_b_busy, 1'b1);
        gnt = 1'b1;
        for (int i = 0; i < 12 && !w_b_done; i++) cyc();
        #1;
        chk("p3_done",     w_b_done, 1'b1);
        chk("p3_done_acc", w_b_acc,  8'd6);
        cyc(); #1;
        chk("p3_idle_ovf", w_b_ovf, 1'b1);
        chk("p3_nwr",      b_addr_q.size() - nb, 4);
        chk("p3_ndone",    b_dones - nd, 1);
        for (int i = 0; i < 4; i++) begin
            chk("p3_log_addr", b_addr_q[nb + i], 32'(i));
            chk("p3_log_data", b_data_q[nb + i], exp_data[i]);
        end

        // ------------------------------------------------ boundaries (BASE=FE)
        do_reset();
        nc = c_addr_q.size(); nd = c_dones;
        exp_addr[0] = 8'hFE; exp_addr[1] = 8'hFF; exp_addr[2] = 8'h00; exp_addr[3] = 8'h01;
        gnt = 1'b1; web = 1'b1; sum = 20'h9;
        cyc(); #1;
        chk("p4_idle_acc", w_c_acc, 8'd0);
        chk("p4_idle_we",  w_c_we,  1'b0);
        cyc(); #1;
        chk("p4_idle_acc2", w_c_acc,  8'd0);
        chk("p4_idle_busy", w_c_busy, 1'b0);
        web = 1'b0; start = 1'b1;
        cyc(); start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            web = 1'b1; sum = 20'(10 + i); start = (i == 1);
            cyc(); #1;
            chk("p4_we",   w_c_we,   1'b1);
            chk("p4_addr", w_c_addr, exp_addr[i]);
        end
        web = 1'b1; sum = 20'hE; start = 1'b1;
        cyc(); #1;
        chk("p4_sat_acc", w_c_acc, 8'd4);
        chk("p4_we_off",  w_c_we,  1'b0);
        web = 1'b0; start = 1'b0;
        cyc(); #1;
        chk("p4_done", w_c_done, 1'b1);
        cyc(); #1;
        cyc(); #1;
        chk("p4_nwr",   c_addr_q.size() - nc, 4);
        chk("p4_ndone", c_dones - nd, 1);
        chk("p4_idle",  w_c_busy, 1'b0);
        for (int i = 0; i < 4; i++) begin
            chk("p4_log_addr", c_addr_q[nc + i], exp_addr[i]);
            chk("p4_log_data", c_data_q[nc + i], 32'(10 + i));
        end

        // ------------------------------------------------ reset mid-job
        do_reset();
        gnt = 1'b1; start = 1'b1;
        cyc(); start = 1'b0;
        web = 1'b1; sum = 20'h31;
        cyc(); #1;
        sum = 20'h32;
        cyc(); #1;
        chk("p5_pre_we",    w_a_we,    1'b1);
        chk("p5_pre_wdata", w_a_wdata, 32'h32);
        web = 1'b0; rst = 1'b0; #1;
        chk("p5_rst_we",   w_a_we,   1'b0);
        chk("p5_rst_busy", w_a_busy, 1'b0);
        chk("p5_rst_acc",  w_a_acc,  8'd0);
        chk("p5_rst_ovf",  w_a_ovf,  1'b0);
        chk("p5_rst_done", w_a_done, 1'b0);
        nlog = a_addr_q.size();
        cyc();
        rst = 1'b1; start = 1'b1;
        cyc(); start = 1'b0; #1;
        chk("p5_restart_busy", w_a_busy, 1'b1);
        chk("p5_restart_we",   w_a_we,   1'b0);
        web = 1'b1; sum = 20'h41;
        cyc(); #1;
        web = 1'b0;
        chk("p5_new_we",    w_a_we,    1'b1);
        chk("p5_new_addr",  w_a_addr,  8'd0);
        chk("p5_new_wdata", w_a_wdata, 32'h41);
        #5;
        chk("p5_nwr",      a_addr_q.size() - nlog, 1);
        chk("p5_log_data", a_data_q[nlog], 32'h41);
        do_reset();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
